ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
- Two-requester round-robin arbiter that shares one single-port synchronous RAM (64 x 8, write on clock edge, registered read address).
- Sits between two client blocks (port A, port B) and the RAM.
- Drives the RAM data, address and write-enable; returns read data to the winning client.
- Supports an optional lock so one client can hold the port across back-to-back accesses, e.g. read-modify-write.

Parameters:
- ADDR_W, 6, RAM address width (depth 2^ADDR_W).
- DATA_W, 8, RAM data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- a_req  in  1  port A access request.
- a_we  in  1  port A: 1 = write, 0 = read.
- a_lock  in  1  port A: keep ownership after this grant.
- a_addr  in  ADDR_W  port A address.
- a_wdata  in  DATA_W  port A write data.
- a_gnt  out  1  port A access accepted this cycle.
- a_rvalid  out  1  port A read data valid (1-cycle pulse).
- b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid: same as port A, for port B.
- rdata  out  DATA_W  read data, shared; qualified by a_rvalid or b_rvalid.
- ram_data  out  DATA_W  to RAM write data.
- ram_addr  out  ADDR_W  to RAM address.
- ram_we  out  1  to RAM write enable.
- ram_q  in  DATA_W  from RAM read data (valid the cycle after the read address is issued).

Behaviour:
- Reset: synchronous, active-high. While rst=1:
  - a_gnt=b_gnt=0, ram_we=0, a_rvalid=b_rvalid=0, rdata=0.
  - Priority pointer set to A; lock owner cleared; read pipeline flushed.
- Grant (combinational within the cycle, from req, pointer and lock state):
  - Lock owner set and still requesting: the owner is granted.
  - Otherwise, both requesting: grant the side the pointer selects.
  - Otherwise, exactly one requesting: grant that side.
  - At most one gnt is high per cycle.
- Handshake:
  - A request is accepted in the cycle where req=1 and gnt=1.
  - A client holds req, we, addr and wdata stable until granted; a denied request is not dropped.
- RAM drive:
  - ram_addr and ram_data mux the granted side's fields.
  - ram_we = gnt & we of the granted side.
  - No grant: ram_we=0 and ram_addr holds the last granted address, so the RAM read register is undisturbed.
- Pointer update on every accepted access: pointer is set to the side that was not granted (strict alternation under contention).
- Lock:
  - Accepted access with lock=1: owner is set to that side.
  - Accepted access with lock=0: owner is cleared.
  - Owner drops req: owner is cleared the same cycle and the other side may win.
- Read latency:
  - Read accepted in cycle N: RAM latches the address at the end of N; ram_q is valid in N+1.
  - Arbiter registers ram_q into rdata at the end of N+1; the owner's rvalid pulses high during N+2.
  - A 2-stage tag pipeline (valid, side) tracks ownership, so back-to-back reads (one per cycle, either side) return in order with no bubbles.
- Writes: complete at the end of the grant cycle; no rvalid.
  - A read of the same address in the next cycle returns the new data.
- rdata holds its last value when no rvalid is high.
- Reset mid-operation: in-flight reads are discarded and no rvalid is issued for them.

Optional Feature:
- Macro: RAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; A always wins under contention and the pointer is not implemented. Lock still applies.
- Undefined (default): round-robin as described above.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then no requests -> all gnt/rvalid 0, ram_we 0, rdata 0x00.
- A writes 0x5A to addr 3, then A reads addr 3 -> a_gnt high on each request; a_rvalid pulses 2 cycles after the read grant with rdata=0x5A; b_rvalid stays 0.
- A and B both request reads continuously (A addr 1 = 0x11, B addr 2 = 0x22) -> grants alternate A,B,A,B; rvalid pulses alternate with rdata 0x11, 0x22, ...; no bubbles.
- A issues 2 accesses with a_lock=1 then 1 access with lock=0, B requesting throughout -> A granted 3 consecutive cycles, then B granted.
- Read accepted, then rst asserted in the next cycle -> no rvalid for that read; pointer back to A.
- With RAM_ARB_FIXED_PRIO_EN defined and both requesting for 4 cycles -> a_gnt high all 4 cycles, b_gnt 0.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port synchronous RAM between two clients.
// Round-robin under contention, with an optional per-access lock so a client can
// keep the port for back-to-back accesses (read-modify-write). Read data returns
// two cycles after the grant and is steered by a tag pipeline.
// Build option: define RAM_ARB_FIXED_PRIO_EN for fixed priority (A wins under
// contention, no priority pointer). Lock still applies in that build.
module ram_port_arbiter #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_req,
   input  logic              a_we,
   input  logic              a_lock,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   input  logic              b_req,
   input  logic              b_we,
   input  logic              b_lock,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic [DATA_W-1:0] ram_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_q
);

   // Side encoding used by pointer, owner and tags: 0 = A, 1 = B.
   logic              prio_b;
   logic              own_vld_q;
   logic              own_side_q;
   logic              gnt_a;
   logic              gnt_b;
   logic              accept;
   logic              owner_req;
   logic              vld_p0;
   logic              side_p0;
   logic              vld_p1;
   logic              side_p1;
   logic [DATA_W-1:0] rdata_p1;
   logic [ADDR_W-1:0] addr_last;

   assign accept    = gnt_a | gnt_b;
   assign owner_req = own_side_q ? b_req : a_req;

`ifdef RAM_ARB_FIXED_PRIO_EN
   assign prio_b = 1'b0;
`else
   logic ptr_q;

   assign prio_b = ptr_q;

   // Priority pointer moves to the side that was not served on every acceptance.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= 1'b0;
      end else if (accept) begin
         ptr_q <= gnt_a;
      end
   end
`endif

   // Grant decision: a requesting lock owner first, then pointer under contention.
   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (!rst) begin
         if (own_vld_q && !own_side_q && a_req) begin
            gnt_a = 1'b1;
         end else if (own_vld_q && own_side_q && b_req) begin
            gnt_b = 1'b1;
         end else if (a_req && b_req) begin
            if (prio_b) begin
               gnt_b = 1'b1;
            end else begin
               gnt_a = 1'b1;
            end
         end else if (a_req) begin
            gnt_a = 1'b1;
         end else if (b_req) begin
            gnt_b = 1'b1;
         end
      end
   end

   assign a_gnt = gnt_a;
   assign b_gnt = gnt_b;

   // RAM port mux; idle cycles replay the last address so the RAM read register holds.
   always_comb begin
      ram_addr = addr_last;
      ram_data = gnt_b ? b_wdata : a_wdata;
      ram_we   = 1'b0;
      if (gnt_a) begin
         ram_addr = a_addr;
         ram_we   = a_we;
      end else if (gnt_b) begin
         ram_addr = b_addr;
         ram_we   = b_we;
      end
   end

   // Lock ownership: set or cleared by each acceptance, dropped when the owner stops requesting.
   always_ff @(posedge clk) begin
      if (rst) begin
         own_vld_q  <= 1'b0;
         own_side_q <= 1'b0;
      end else if (accept) begin
         own_vld_q  <= gnt_a ? a_lock : b_lock;
         own_side_q <= gnt_b;
      end else if (own_vld_q && !owner_req) begin
         own_vld_q  <= 1'b0;
      end
   end

   // Stage p0: read accepted, RAM latches the address at this edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p0 <= (gnt_a & ~a_we) | (gnt_b & ~b_we);
         vld_p1 <= vld_p0;
      end
   end

   // Tag side and last address travel without reset; they are only meaningful with a valid.
   always_ff @(posedge clk) begin
      side_p0 <= gnt_b;
      side_p1 <= side_p0;
      if (accept) begin
         addr_last <= ram_addr;
      end
   end

   // Stage p1: capture ram_q for the tracked read; rdata holds between reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_p1 <= '0;
      end else if (vld_p0) begin
         rdata_p1 <= ram_q;
      end
   end

   assign a_rvalid = vld_p1 & ~side_p1 & ~rst;
   assign b_rvalid = vld_p1 &  side_p1 & ~rst;
   assign rdata    = rst ? '0 : rdata_p1;

endmodule
